// File: rtl/cover_toggle_collector.sv
// Toggle-coverage collector: captures per-bit toggle events into a pending bitmap,
// serialises them lowest-index first through a fall-through FIFO onto a valid/ready port.
module cover_toggle_collector #(
    parameter int unsigned     WIDTH       = 7,
    parameter longint unsigned COVER_INDEX = 0,
    parameter longint unsigned COVER_TOTAL = 28338,
    parameter int unsigned     FIFO_DEPTH  = 4,
    parameter bit              FIRST_ONLY  = 1'b1
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [WIDTH-1:0]           valid,
    input  logic                       enable,
    input  logic                       clear,
    output logic                       rpt_valid,
    input  logic                       rpt_ready,
    output logic [63:0]                rpt_index,
    output logic [$clog2(WIDTH+1)-1:0] hit_count,
    output logic                       all_hit,
    output logic [15:0]                drop_count
);

    localparam int unsigned CNTW = $clog2(WIDTH + 1);
    localparam int unsigned SELW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned PW   = AW + 1;

`ifndef SYNTHESIS
    if (COVER_INDEX + 64'(WIDTH) > COVER_TOTAL) begin : g_index_range_check
        $error("cover_toggle_collector: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
    end
`endif

    logic [WIDTH-1:0] valid_q, valid_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] hit_q, hit_d;
    logic [SELW-1:0]  mem_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]  hit_count_q, hit_count_d;
    logic [15:0]      drop_count_q, drop_count_d;

    logic [SELW-1:0]  sel;
    logic             any_pend;
    logic [PW-1:0]    fifo_count;
    logic             fifo_full;
    logic             pop;
    logic             push;
    logic [WIDTH-1:0] drain_mask;
    logic [WIDTH-1:0] set_vec;
    logic [WIDTH-1:0] merge_vec;
    logic [CNTW-1:0]  merge_cnt;
    logic [16:0]      drop_sum;
    logic             new_hit;

    // Lowest-index pending bit wins the single drain slot each cycle.
    always_comb begin
        sel      = '0;
        any_pend = |pending_q;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (pending_q[i]) sel = SELW'(i);
        end
    end

    always_comb begin
        fifo_count = wr_ptr_q - rd_ptr_q;
        fifo_full  = (fifo_count == PW'(FIFO_DEPTH));
        rpt_valid  = (wr_ptr_q != rd_ptr_q);
        pop        = rpt_valid & rpt_ready;
        push       = any_pend & (~fifo_full | pop);
        drain_mask = push ? (WIDTH'(1) << sel) : '0;
        rpt_index  = rpt_valid ? (COVER_INDEX + 64'(mem_q[rd_ptr_q[AW-1:0]])) : 64'd0;
    end

    // Sticky mode ignores bits already hit or queued; counting mode merges repeats.
    always_comb begin
        valid_d   = enable ? valid : '0;
        set_vec   = '0;
        merge_vec = '0;
        if (FIRST_ONLY) begin
            set_vec = valid_q & ~hit_q & ~pending_q;
        end else begin
            set_vec   = valid_q;
            merge_vec = valid_q & pending_q & ~drain_mask;
        end
        pending_d = (pending_q & ~drain_mask) | set_vec;
        hit_d     = hit_q | drain_mask;
        new_hit   = push & ((drain_mask & ~hit_q) != '0);
        hit_count_d = hit_count_q + CNTW'(new_hit);
        merge_cnt = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            merge_cnt = merge_cnt + CNTW'(merge_vec[i]);
        end
        drop_sum     = {1'b0, drop_count_q} + 17'(merge_cnt);
        drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q      <= '0;
            pending_q    <= '0;
            hit_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            hit_count_q  <= '0;
            drop_count_q <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
        end else if (clear) begin
            valid_q      <= '0;
            pending_q    <= '0;
            hit_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            hit_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            valid_q      <= valid_d;
            pending_q    <= pending_d;
            hit_q        <= hit_d;
            hit_count_q  <= hit_count_d;
            drop_count_q <= drop_count_d;
            if (push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= sel;
                wr_ptr_q                <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    assign hit_count  = hit_count_q;
    assign drop_count = drop_count_q;
    assign all_hit    = (hit_count_q == CNTW'(WIDTH));

endmodule
